// File: rtl/core_clk_reset_seq.sv
// Reset/clock-enable sequencer behind the core PLL: filters lock, holds reset, then emits phase-aligned enables.
// Latency: 2-cycle lock synchronizer, then 1+LOCK_FILTER+RESET_HOLD cycles to reset release; loss of lock reaches reset in 2 cycles.
// Backpressure: none; free-running sequencer. Outputs decode registered state only.
module core_clk_reset_seq #(
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int DIV_MID     = 3,
  parameter int DIV_SLOW    = 12,
  parameter int SLOW_PHASE  = 3
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  output logic core_reset,
  output logic ce_mid,
  output logic ce_slow,
  output logic ce_slow_q,
  output logic lock_lost
);

  localparam int MAX_LF_RH = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
  localparam int MAX_CNT   = (MAX_LF_RH > DIV_SLOW) ? MAX_LF_RH : DIV_SLOW;
  localparam int CW        = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int PW        = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam int MW        = (DIV_MID > 1) ? $clog2(DIV_MID) : 1;

  localparam logic [CW-1:0] LF_LAST   = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] RH_LAST   = CW'(RESET_HOLD - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(DIV_SLOW - 1);
  localparam logic [PW-1:0] PH_SHIFT  = PW'(SLOW_PHASE);
  localparam logic [MW-1:0] MID_LAST  = MW'(DIV_MID - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] ph, ph_nxt;
  logic [MW-1:0] mid_ph, mid_ph_nxt;
  logic          s1, locked_s;
  logic          lost_set;

  // State, counters, lock synchronizer and sticky loss flag; rst overrides everything.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      ph        <= '0;
      mid_ph    <= '0;
      s1        <= 1'b0;
      locked_s  <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ph       <= ph_nxt;
      mid_ph   <= mid_ph_nxt;
      s1       <= pll_locked;
      locked_s <= s1;
      if (lost_set) lock_lost <= 1'b1;
    end
  end

  // Next-state: a lock drop is checked first so it beats any forward transition.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ph_nxt     = ph;
    mid_ph_nxt = mid_ph;
    lost_set   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) state_nxt = FILTER;
      end
      FILTER: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LF_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == RH_LAST) begin
          state_nxt  = RUN;
          cnt_nxt    = '0;
          ph_nxt     = '0;
          mid_ph_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = WAIT_LOCK;
          lost_set   = 1'b1;
          ph_nxt     = '0;
          mid_ph_nxt = '0;
        end else begin
          // mid_ph tracks ph mod DIV_MID without a divider
          ph_nxt     = (ph == PH_LAST) ? '0 : ph + 1'b1;
          mid_ph_nxt = (mid_ph == MID_LAST) ? '0 : mid_ph + 1'b1;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // Output decode from registered state and phase counters only.
  always_comb begin
    core_reset = (state != RUN);
    ce_mid     = (state == RUN) && (mid_ph == '0);
    ce_slow    = (state == RUN) && (ph == '0);
    ce_slow_q  = (state == RUN) && (ph == PH_SHIFT);
  end

endmodule

// File: doc/core_clk_reset_seq.md
# core_clk_reset_seq

Reset and clock-enable sequencer that sits directly downstream of the core PLL, in the 96 MHz system domain. It synchronizes and filters the PLL `locked` output and holds the core in reset until lock is stable. It then releases reset and generates phase-aligned clock enables that stand in for the 32 MHz and 8 MHz PLL outputs, including the quarter-period-shifted 8 MHz phase. On any loss of lock it drops back to reset and records the event.

## Interface
Parameters:
- `LOCK_FILTER`, 1024: consecutive synchronized-locked cycles required before the hold phase; ≥1.
- `RESET_HOLD`, 256: cycles `core_reset` stays high after the filter passes; ≥1.
- `DIV_MID`, 3: system cycles per `ce_mid` pulse (96/32 MHz).
- `DIV_SLOW`, 12: system cycles per `ce_slow` pulse (96/8 MHz). Must be an integer multiple of `DIV_MID`.
- `SLOW_PHASE`, 3: offset of `ce_slow_q` after `ce_slow` (31.25 ns = 3 × 10.42 ns). Must satisfy 0 < `SLOW_PHASE` < `DIV_SLOW`.

Ports:
- `clk_sys` in 1: 96 MHz system clock (PLL outclk_0).
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL lock; asynchronous to `clk_sys`.
- `core_reset` out 1: active-high reset to the core.
- `ce_mid` out 1: one-cycle enable, period `DIV_MID`.
- `ce_slow` out 1: one-cycle enable, period `DIV_SLOW`.
- `ce_slow_q` out 1: `ce_slow` delayed by `SLOW_PHASE` cycles, same period.
- `lock_lost` out 1: sticky flag; set when lock drops while in RUN, cleared only by `rst`.

## Operation
- Synchronizer: 2-flop chain `pll_locked` → `s1` → `locked_s`. No other logic reads `pll_locked`.
- FSM states: WAIT_LOCK, FILTER, HOLD, RUN. One shared counter `cnt` is sized by clog2 of max(`LOCK_FILTER`, `RESET_HOLD`, `DIV_SLOW`).
- WAIT_LOCK: `cnt` = 0. If `locked_s` = 1, go to FILTER with `cnt` = 0.
- FILTER:
  - If `locked_s` = 0, go to WAIT_LOCK with `cnt` = 0.
  - Else if `cnt` = `LOCK_FILTER`−1, go to HOLD with `cnt` = 0.
  - Else `cnt`++.
- HOLD:
  - If `locked_s` = 0, go to WAIT_LOCK.
  - Else if `cnt` = `RESET_HOLD`−1, go to RUN with divider phase = 0.
  - Else `cnt`++.
- RUN:
  - Divider phase `ph` counts 0..`DIV_SLOW`−1 and wraps to 0.
  - If `locked_s` = 0, go to WAIT_LOCK, set `lock_lost`, and clear `ph`.
- Outputs are decoded from registered state and `ph` only; there are no combinational paths from inputs to outputs.
  - `core_reset` = (state ≠ RUN).
  - `ce_mid` = RUN && (`ph` mod `DIV_MID` = 0).
  - `ce_slow` = RUN && (`ph` = 0).
  - `ce_slow_q` = RUN && (`ph` = `SLOW_PHASE`).
- `ph` mod `DIV_MID` is held in a separate wrap counter, so no divider is used.
- Simultaneous events:
  - `rst` wins over everything.
  - A `locked_s` drop wins over a FILTER→HOLD or HOLD→RUN transition on the same cycle.
- Reset values: state WAIT_LOCK, `cnt` = 0, `ph` = 0, `s1` = `locked_s` = 0, `core_reset` = 1, all enables = 0, `lock_lost` = 0.

## Timing
- Synchronizer latency: `pll_locked` high before edge E1 gives `locked_s` = 1 after E2.
- Bring-up: state is FILTER after E3 and HOLD after E(3+`LOCK_FILTER`). `core_reset` falls after E(3+`LOCK_FILTER`+`RESET_HOLD`).
- The first RUN cycle has `ce_mid` = `ce_slow` = 1. `ce_slow_q` first pulses `SLOW_PHASE` cycles later.
- Steady state:
  - `ce_mid` pulses every 3 cycles; `ce_slow` every 12.
  - Every `ce_slow` coincides with a `ce_mid`.
  - `ce_slow_q` coincides with a `ce_mid` at the default parameters (3 mod 3 = 0).
- Lock loss: `pll_locked` low before edge L gives `locked_s` = 0 after L+1. After L+2, `core_reset` = 1, enables = 0 and `lock_lost` = 1.
- `rst` asserted on any cycle: all state, counters and outputs take reset values after the next edge. Enables are 0 from that edge on.

## Test plan
- Bring-up (`LOCK_FILTER`=4, `RESET_HOLD`=8): `pll_locked` high before E1 → `core_reset` 1 through E14 and 0 after E15. `ce_mid`/`ce_slow` = 1 on the first RUN cycle.
- Cadence: 48 RUN cycles → exactly 16 `ce_mid`, 4 `ce_slow` and 4 `ce_slow_q` pulses. Each `ce_slow_q` is exactly 3 cycles after a `ce_slow`. All enables are one cycle wide.
- Filter glitch: `pll_locked` low for 1 cycle midway through FILTER → state returns to WAIT_LOCK, and the full 1+`LOCK_FILTER`+`RESET_HOLD` sequence restarts from the next `locked_s` high. `lock_lost` stays 0.
- Loss in RUN: drop `pll_locked` after 20 RUN cycles → `core_reset` = 1 and enables = 0 two edges after the sampled drop, with `lock_lost` = 1. Relock → reset releases again and `lock_lost` stays 1.
- `rst` mid-HOLD with `pll_locked` held high → all reset values after the next edge. Deassert `rst` → full bring-up latency of 15 edges is re-observed.
- `rst` after `lock_lost` = 1 → `lock_lost` = 0. `pll_locked` toggling every cycle never reaches RUN.
